// File: rtl/adc_pack_pkg.sv
// adc_pack_pkg: shared state type, sample width and sign-extension helper for adc_sample_packer
package adc_pack_pkg;
   typedef enum logic [1:0] {IDLE, PACK, DROP} pack_state_t;
   localparam int SAMPLE_W = 16;
   // Left-align the raw sample, then arithmetic-shift back to replicate its sign bit.
   function automatic logic [SAMPLE_W-1:0] sext16(input logic [SAMPLE_W-1:0] raw, input int width);
      logic signed [SAMPLE_W-1:0] t;
      t = raw << (SAMPLE_W - width);
      return t >>> (SAMPLE_W - width);
   endfunction
endpackage

// File: rtl/axis_fifo_fwft.sv
// axis_fifo_fwft: first-word-fall-through FIFO
// Ports: clk, rst (async, active-high); wr_en_i/wr_data_i push; rd_en_i pops the head;
// rd_data_o shows the head (zero when empty); full_o/empty_o status. Push while full is
// accepted when a pop happens in the same cycle.
module axis_fifo_fwft #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic wr, rd;
   assign empty_o = wr_ptr_q == rd_ptr_q;
   assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd = rd_en_i && !empty_o;
   assign wr = wr_en_i && (!full_o || rd);
   assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   always_ff @(posedge clk)
      if (wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
endmodule

// File: rtl/adc_sample_packer.sv
// adc_sample_packer: packs sign-extended ADC samples into framed AXI-Stream words, dropping whole frames on overflow
// Ports: clk, rst (async, active-high); en capture enable (checked at frame boundaries);
// in_data/in_valid sample input; m_axis_tdata/tvalid/tready/tlast output stream;
// overflow_cnt saturating dropped-frame count; busy high while packing or dropping.
module adc_sample_packer
   import adc_pack_pkg::*;
#(
   parameter int DATA_WIDTH  = 12,
   parameter int LANES       = 4,
   parameter int FRAME_WORDS = 256,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [DATA_WIDTH-1:0]     in_data,
   input  logic                      in_valid,
   output logic [SAMPLE_W*LANES-1:0] m_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tlast,
   output logic [31:0]               overflow_cnt,
   output logic                      busy
);
   localparam int DW = SAMPLE_W * LANES;
   localparam int LW = $clog2(LANES);
   localparam int WW = $clog2(FRAME_WORDS);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
   localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);
   pack_state_t state_q, state_d;
   logic [LW-1:0] lane_q, lane_d;
   logic [WW-1:0] word_q, word_d;
   logic [DW-SAMPLE_W-1:0] pack_q, pack_d;
   logic [31:0] ovf_q, ovf_d;
   logic [DW-1:0] word_full;
   logic [DW:0] fifo_out;
   logic full, empty, rd, wr_try, wr_ok, word_done, frame_end;
   // Lower lanes live in a right-shifting register; the current sample completes the word.
   assign word_full = {sext16(SAMPLE_W'(in_data), DATA_WIDTH), pack_q};
   assign rd = !empty && m_axis_tready;
   assign wr_ok = !full || rd;
   assign word_done = state_q != IDLE && in_valid && lane_q == LAST_LANE;
   assign frame_end = word_done && word_q == LAST_WORD;
   assign wr_try = state_q == PACK && word_done;
   always_comb begin
      state_d = state_q;
      lane_d = lane_q;
      word_d = word_q;
      pack_d = pack_q;
      ovf_d = ovf_q;
      if (state_q == IDLE) state_d = en ? PACK : IDLE;
      else if (in_valid) begin
         lane_d = lane_q + 1'b1;
         word_d = !word_done ? word_q : frame_end ? '0 : word_q + 1'b1;
         if (state_q == PACK) pack_d = word_full[DW-1:SAMPLE_W];
         if (wr_try && !wr_ok) begin
            state_d = DROP;
            ovf_d = ovf_q + 32'(ovf_q != '1);
         end
         // Frame end wins over a refusal on the last word: nothing left to drop.
         if (frame_end) state_d = en ? PACK : IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         lane_q <= '0;
         word_q <= '0;
         pack_q <= '0;
         ovf_q <= '0;
      end else begin
         state_q <= state_d;
         lane_q <= lane_d;
         word_q <= word_d;
         pack_q <= pack_d;
         ovf_q <= ovf_d;
      end
   axis_fifo_fwft #(.WIDTH(DW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_try && wr_ok),
      .wr_data_i ({frame_end, word_full}),
      .rd_en_i   (m_axis_tready),
      .rd_data_o (fifo_out),
      .full_o    (full),
      .empty_o   (empty)
   );
   assign {m_axis_tlast, m_axis_tdata} = fifo_out;
   assign m_axis_tvalid = !empty;
   assign overflow_cnt = ovf_q;
   assign busy = state_q != IDLE;
endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: randomized self-checking bench for adc_sample_packer against a sample-level frame model
module tb_adc_sample_packer;
   localparam int DW = 12, L = 4, FW = 4, FD = 4, FS = FW * L;
   logic clk = 0, rst = 1, en = 0, in_valid = 0, m_axis_tready = 0;
   logic [DW-1:0] in_data = '0;
   logic [16*L-1:0] m_axis_tdata;
   logic m_axis_tvalid, m_axis_tlast, busy;
   logic [31:0] overflow_cnt;
   int n_vec = 0, n_bad = 0;
   logic [16*L:0] exp_q[$];
   logic [15:0] m_cur[$];
   logic m_active = 0, m_drop = 0;
   int m_cnt = 0;
   logic [31:0] m_ovf = 0;
   int got_n = 0;
   logic got_last[$];

   always #5 clk = ~clk;

   adc_sample_packer #(.DATA_WIDTH(DW), .LANES(L), .FRAME_WORDS(FW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .overflow_cnt(overflow_cnt), .busy(busy)
   );

   task automatic model_reset;
      exp_q.delete();
      m_cur.delete();
      m_active = 0;
      m_drop = 0;
      m_cnt = 0;
      m_ovf = 0;
   endtask

   // Drives one cycle from a negedge and advances the frame model by the same cycle.
   task automatic step(input logic e, input logic v, input logic [DW-1:0] d, input logic r);
      int occ;
      logic rdm;
      logic [16*L-1:0] w;
      en = e; in_valid = v; in_data = d; m_axis_tready = r;
      if (m_axis_tvalid && r) begin
         got_n++;
         got_last.push_back(m_axis_tlast);
      end
      occ = exp_q.size();
      rdm = occ != 0 && r;
      if (rdm) void'(exp_q.pop_front());
      if (!m_active) m_active = e;
      else if (v) begin
         if (!m_drop) begin
            m_cur.push_back({{(16-DW){d[DW-1]}}, d});
            if (m_cur.size() == L) begin
               w = '0;
               for (int i = 0; i < L; i++) w[16*i +: 16] = m_cur[i];
               if (occ < FD || rdm) exp_q.push_back({m_cnt == FS - 1, w});
               else begin
                  m_drop = 1;
                  if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
               end
               m_cur.delete();
            end
         end
         m_cnt++;
         if (m_cnt == FS) begin
            m_cnt = 0;
            m_drop = 0;
            m_active = e;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_vec++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
      n_vec++; if (m_axis_tdata !== '0) begin n_bad++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
      n_vec++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
      n_vec++; if (overflow_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_ovf got=%0d exp=0", overflow_cnt); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 0;
      model_reset();
   endtask

   task automatic test_packing;
      logic [DW-1:0] s[4];
      s[0] = 12'h001; s[1] = 12'h002; s[2] = 12'hFFF; s[3] = 12'h800;
      step(1, 0, '0, 1);
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pack_busy got=%b exp=1", busy); end
      for (int i = 0; i < 4; i++) step(1, 1, s[i], 1);
      n_vec++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL pack_tvalid got=%b exp=1", m_axis_tvalid); end
      n_vec++; if (m_axis_tdata !== 64'hF800_FFFF_0002_0001) begin n_bad++; $display("FAIL pack_tdata got=%h exp=f800ffff00020001", m_axis_tdata); end
      n_vec++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL pack_tlast got=%b exp=0", m_axis_tlast); end
      step(1, 0, '0, 1);
      n_vec++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL pack_one_cycle got=%b exp=0", m_axis_tvalid); end
      for (int i = 0; i < FS - 4; i++) begin
         step(1, 1, DW'($urandom), 1);
         n_vec++; if (m_axis_tvalid !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL pack_fill_tvalid got=%b exp=%b", m_axis_tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin n_bad++; $display("FAIL pack_fill_word got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, exp_q[0]); end
         end
      end
      step(1, 0, '0, 1);
   endtask

   task automatic test_framing;
      int lasts;
      got_n = 0; got_last.delete();
      for (int i = 0; i < 2 * FS; i++) begin
         step(1, 1, DW'($urandom), 1);
         n_vec++; if (m_axis_tvalid !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL frame_tvalid got=%b exp=%b", m_axis_tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin n_bad++; $display("FAIL frame_word got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, exp_q[0]); end
         end
      end
      step(1, 0, '0, 1);
      lasts = 0;
      foreach (got_last[i]) lasts += int'(got_last[i]);
      n_vec++; if (got_n != 8) begin n_bad++; $display("FAIL frame_count got=%0d exp=8", got_n); end
      n_vec++; if (lasts != 2 || got_n < 8 || got_last[3] !== 1'b1 || got_last[7] !== 1'b1) begin n_bad++; $display("FAIL frame_tlast_pos got=%0d lasts exp=2 at words 4,8", lasts); end
      n_vec++; if (overflow_cnt !== 32'd0) begin n_bad++; $display("FAIL frame_ovf got=%0d exp=0", overflow_cnt); end
   endtask

   task automatic test_overflow;
      int budget;
      for (int i = 0; i < 3 * FS; i++) begin
         step(1, 1, DW'($urandom), 0);
         n_vec++; if (overflow_cnt !== m_ovf) begin n_bad++; $display("FAIL ovf_cnt_track got=%0d exp=%0d", overflow_cnt, m_ovf); end
         if (exp_q.size() != 0) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin n_bad++; $display("FAIL ovf_head got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, exp_q[0]); end
         end
      end
      n_vec++; if (overflow_cnt !== 32'd2) begin n_bad++; $display("FAIL ovf_cnt got=%0d exp=2", overflow_cnt); end
      got_n = 0; got_last.delete();
      budget = 0;
      while (exp_q.size() != 0 && budget < 10) begin
         step(1, 0, '0, 1);
         budget++;
         if (exp_q.size() != 0) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin n_bad++; $display("FAIL ovf_drain_word got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, exp_q[0]); end
         end
      end
      n_vec++; if (got_n != 4 || got_last[3] !== 1'b1 || got_last[0] !== 1'b0) begin n_bad++; $display("FAIL ovf_drain got=%0d words exp=4 with tlast on 4th", got_n); end
      n_vec++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty got=%b exp=0", m_axis_tvalid); end
      got_n = 0; got_last.delete();
      for (int i = 0; i < FS; i++) begin
         step(1, 1, DW'($urandom), 1);
         if (exp_q.size() != 0) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin n_bad++; $display("FAIL ovf_resume_word got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, exp_q[0]); end
         end
      end
      step(1, 0, '0, 1);
      n_vec++; if (got_n != 4 || got_last[3] !== 1'b1) begin n_bad++; $display("FAIL ovf_resume got=%0d words exp=4 with tlast", got_n); end
      n_vec++; if (overflow_cnt !== 32'd2) begin n_bad++; $display("FAIL ovf_resume_cnt got=%0d exp=2", overflow_cnt); end
   endtask

   task automatic test_enable_drop;
      got_n = 0; got_last.delete();
      for (int i = 0; i < FS; i++) begin
         step(i < 6, 1, DW'($urandom), 1);
         n_vec++; if (busy !== m_active) begin n_bad++; $display("FAIL endrop_busy sample=%0d got=%b exp=%b", i + 1, busy, m_active); end
         if (exp_q.size() != 0) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin n_bad++; $display("FAIL endrop_word got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, exp_q[0]); end
         end
      end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL endrop_idle got=%b exp=0", busy); end
      for (int i = 0; i < 8; i++) step(0, 1, DW'($urandom), 1);
      n_vec++; if (got_n != 4 || got_last[3] !== 1'b1) begin n_bad++; $display("FAIL endrop_words got=%0d exp=4 with tlast", got_n); end
      n_vec++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL endrop_quiet tvalid=%b busy=%b exp=0,0", m_axis_tvalid, busy); end
   endtask

   task automatic test_mid_reset;
      logic [DW-1:0] s[4];
      logic [16*L-1:0] w;
      step(1, 0, '0, 0);
      for (int i = 0; i < 10; i++) step(1, 1, DW'($urandom), 0);
      n_vec++; if (m_axis_tvalid !== 1'b1) begin n_bad++; $display("FAIL mrst_queued got=%b exp=1", m_axis_tvalid); end
      rst = 1;
      #1;
      n_vec++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL mrst_tvalid got=%b exp=0", m_axis_tvalid); end
      n_vec++; if (overflow_cnt !== 32'd0) begin n_bad++; $display("FAIL mrst_ovf got=%0d exp=0", overflow_cnt); end
      n_vec++; if (busy !== 1'b0 || m_axis_tdata !== '0) begin n_bad++; $display("FAIL mrst_out busy=%b tdata=%h exp=0,0", busy, m_axis_tdata); end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      step(1, 0, '0, 1);
      w = '0;
      for (int i = 0; i < 4; i++) begin
         s[i] = DW'($urandom);
         w[16*i +: 16] = 16'(signed'(s[i]));
         step(1, 1, s[i], 1);
      end
      n_vec++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w || m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL mrst_word0 got=%b/%h/%b exp=1/%h/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, w); end
      for (int i = 0; i < FS - 4; i++) step(1, 1, DW'($urandom), 1);
      step(1, 0, '0, 1);
   endtask

   task automatic test_backpressure;
      logic pv, pr;
      logic [16*L:0] pw;
      int lasts, budget;
      got_n = 0; got_last.delete();
      budget = 0;
      for (int i = 0; i < 4 * FS || (exp_q.size() != 0 && budget < 40); i++) begin
         pv = m_axis_tvalid;
         pw = {m_axis_tlast, m_axis_tdata};
         pr = (i % 4 == 0) || (i % 4 == 3);
         if (i >= 4 * FS) budget++;
         step(1, i < 4 * FS, DW'($urandom), pr);
         if (pv && !pr) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== pw) begin n_bad++; $display("FAIL bp_hold got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, pw); end
         end
         n_vec++; if (m_axis_tvalid !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL bp_tvalid got=%b exp=%b", m_axis_tvalid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            n_vec++; if ({m_axis_tlast, m_axis_tdata} !== exp_q[0]) begin n_bad++; $display("FAIL bp_word got=%h exp=%h", {m_axis_tlast, m_axis_tdata}, exp_q[0]); end
         end
      end
      lasts = 0;
      foreach (got_last[i]) lasts += int'(got_last[i]);
      n_vec++; if (got_n != 16 || lasts != 4) begin n_bad++; $display("FAIL bp_count got=%0d words %0d lasts exp=16,4", got_n, lasts); end
      n_vec++; if (overflow_cnt !== 32'd0) begin n_bad++; $display("FAIL bp_ovf got=%0d exp=0", overflow_cnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_packing();
      test_framing();
      test_overflow();
      test_enable_drop();
      test_mid_reset();
      test_backpressure();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
